// File: rtl/crtc_pkg.sv
// Shared constants and types for the character-mode CRT timing controller.
// Defaults describe 640x480 text timing with 8-pixel character clocks.
package crtc_pkg;

    localparam int H_ACTIVE_DEF     = 80;
    localparam int H_FP_DEF         = 2;
    localparam int H_SYNC_DEF       = 12;
    localparam int H_BP_DEF         = 6;
    localparam int V_ROWS_DEF       = 30;
    localparam int CHAR_H_DEF       = 16;
    localparam int V_FP_DEF         = 10;
    localparam int V_SYNC_DEF       = 2;
    localparam int V_BP_DEF         = 33;
    localparam int AW_DEF           = 13;
    localparam int BLINK_FRAMES_DEF = 16;
    localparam int RA_W             = 5;

    typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} phase_t;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/crtc_axis_counter.sv
// One timing axis: counter that wraps at ACTIVE+FP+SYNC+BP and reports
// which phase of the line/frame the current count falls in.
module crtc_axis_counter
    import crtc_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF,
    parameter int CW     = $clog2(ACTIVE + FP + SYNC + BP)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          advance,
    output logic [CW-1:0] count,
    output logic          wrap,
    output phase_t        phase
);

    localparam int TOT = axis_total(ACTIVE, FP, SYNC, BP);

    assign wrap = advance && (count == CW'(TOT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (advance) begin
            count <= wrap ? '0 : count + CW'(1);
        end
    end

    always_comb begin
        phase = PH_BP;
        if (count < CW'(ACTIVE))
            phase = PH_ACTIVE;
        else if (count < CW'(ACTIVE + FP))
            phase = PH_FP;
        else if (count < CW'(ACTIVE + FP + SYNC))
            phase = PH_SYNC;
    end

endmodule

// File: rtl/crtc_timing.sv
// Parametrised character-mode CRT controller: DE/HS/VS, RA and MA with scroll base.
// Define CRTC_CURSOR_EN to build the blinking hardware cursor; otherwise cursor is tied low.
module crtc_timing
    import crtc_pkg::*;
#(
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int H_FP         = H_FP_DEF,
    parameter int H_SYNC       = H_SYNC_DEF,
    parameter int H_BP         = H_BP_DEF,
    parameter int V_ROWS       = V_ROWS_DEF,
    parameter int CHAR_H       = CHAR_H_DEF,
    parameter int V_FP         = V_FP_DEF,
    parameter int V_SYNC       = V_SYNC_DEF,
    parameter int V_BP         = V_BP_DEF,
    parameter bit HS_POL       = 1'b0,
    parameter bit VS_POL       = 1'b0,
    parameter int AW           = AW_DEF,
    parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clk_en,
    input  logic [AW-1:0]   start_addr,
    input  logic [AW-1:0]   cursor_addr,
    input  logic [RA_W-1:0] cur_start,
    input  logic [RA_W-1:0] cur_end,
    output logic            de,
    output logic            hs,
    output logic            vs,
    output logic [RA_W-1:0] ra,
    output logic [AW-1:0]   ma,
    output logic            frame_start,
    output logic            cursor
);

    localparam int V_ACTIVE = V_ROWS * CHAR_H;
    localparam int H_TOT    = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT    = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HCW      = $clog2(H_TOT);
    localparam int VCW      = $clog2(V_TOT);

    logic [HCW-1:0]  h_count;
    logic [VCW-1:0]  v_count;
    logic            h_wrap;
    logic            v_wrap_unused;
    phase_t          h_phase;
    phase_t          v_phase;

    logic [AW-1:0]   row_base;
    logic [RA_W-1:0] ra_cnt;
    logic            frame_first;
    logic            line_active;
    logic            de_now;
    logic            row_last;
    logic [AW-1:0]   base_now;
    logic [AW-1:0]   ma_now;

    crtc_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(HCW)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .advance(clk_en),
        .count(h_count), .wrap(h_wrap), .phase(h_phase)
    );

    crtc_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(VCW)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .advance(h_wrap),
        .count(v_count), .wrap(v_wrap_unused), .phase(v_phase)
    );

    assign frame_first = (h_count == '0) && (v_count == '0);
    assign line_active = (v_phase == PH_ACTIVE);
    assign de_now      = (h_phase == PH_ACTIVE) && line_active;
    assign row_last    = (ra_cnt == RA_W'(CHAR_H - 1));
    // Row base is only reloaded on this edge, so the first cell uses the live input.
    assign base_now    = frame_first ? start_addr : row_base;
    assign ma_now      = base_now + AW'(h_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_base    <= '0;
            ra_cnt      <= '0;
            de          <= 1'b0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            ra          <= '0;
            ma          <= '0;
            frame_start <= 1'b0;
        end else if (clk_en) begin
            de          <= de_now;
            hs          <= (h_phase == PH_SYNC) ? HS_POL : ~HS_POL;
            vs          <= (v_phase == PH_SYNC) ? VS_POL : ~VS_POL;
            ra          <= ra_cnt;
            frame_start <= frame_first;
            if (de_now)
                ma <= ma_now;

            if (frame_first)
                row_base <= start_addr;
            else if (h_wrap && line_active && row_last)
                row_base <= row_base + AW'(H_ACTIVE);

            if (h_wrap && line_active)
                ra_cnt <= row_last ? '0 : ra_cnt + RA_W'(1);
        end
    end

`ifdef CRTC_CURSOR_EN
    localparam int BCW = $clog2(BLINK_FRAMES + 1);

    logic [AW-1:0]  cursor_lat;
    logic [BCW-1:0] blink_cnt;
    logic           blink_on;
    logic           blink_flip;
    logic           blink_now;
    logic [AW-1:0]  cur_addr_now;
    logic           cur_hit;

    // blink_cnt counts frame starts; reaching BLINK_FRAMES flips the phase for the new frame.
    assign blink_flip   = frame_first && (blink_cnt == BCW'(BLINK_FRAMES));
    assign blink_now    = blink_flip ? ~blink_on : blink_on;
    assign cur_addr_now = frame_first ? cursor_addr : cursor_lat;
    assign cur_hit      = de_now && (ma_now == cur_addr_now) &&
                          (cur_start <= ra_cnt) && (ra_cnt <= cur_end) && blink_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cursor_lat <= '0;
            blink_cnt  <= '0;
            blink_on   <= 1'b1;
            cursor     <= 1'b0;
        end else if (clk_en) begin
            cursor <= cur_hit;
            if (frame_first) begin
                cursor_lat <= cursor_addr;
                blink_on   <= blink_now;
                blink_cnt  <= blink_flip ? BCW'(1) : blink_cnt + BCW'(1);
            end
        end
    end
`else
    logic unused_cursor_in;
    assign unused_cursor_in = ^{cursor_addr, cur_start, cur_end};
    assign cursor = 1'b0;
`endif

endmodule
